// File: rtl/alu_sequencer.sv
// Request sequencer for a 4-bit ALU: add/sub/mul in place, div via a shared external divider.
// Define ALU_TIMEOUT_EN to bound the wait for div_done to TIMEOUT_CYCLES cycles (result 8'hEE, err=1).
module alu_sequencer #(
   parameter int TIMEOUT_CYCLES = 32
) (
   input  logic       clk,
   input  logic       n_rst,
   input  logic       parser_done,
   input  logic [1:0] op,
   input  logic [3:0] opa,
   input  logic [3:0] opb,
   output logic [3:0] div_M,
   output logic [3:0] div_Q,
   output logic       div_start,
   input  logic [7:0] div_result,
   input  logic       div_done,
   output logic [7:0] result,
   output logic       err,
   output logic       result_valid,
   input  logic       result_ready,
   output logic       overflow
);

   localparam logic [1:0] IDLE     = 2'd0;
   localparam logic [1:0] EXEC     = 2'd1;
   localparam logic [1:0] WAIT_DIV = 2'd2;
   localparam logic [1:0] OUT      = 2'd3;

   logic [1:0] state;
   logic [1:0] act_op;
   logic [3:0] act_a;
   logic [3:0] act_b;
   logic       pend_valid;
   logic [1:0] pend_op;
   logic [3:0] pend_a;
   logic [3:0] pend_b;
   logic [7:0] alu_out;
   logic       transfer;

`ifdef ALU_TIMEOUT_EN
   localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
   logic [CW-1:0] cnt;
`endif

   // result_valid is only ever high in OUT, so transfer implies state == OUT
   assign transfer = result_valid & result_ready;

   always_comb begin
      alu_out = '0;
      case (act_op)
         2'b00:   alu_out = {3'b000, {1'b0, act_a} + {1'b0, act_b}};
         2'b01:   alu_out = {4'b0000, act_a} - {4'b0000, act_b};
         2'b10:   alu_out = {4'b0000, act_a} * {4'b0000, act_b};
         default: alu_out = '0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!n_rst) begin
         state        <= IDLE;
         act_op       <= '0;
         act_a        <= '0;
         act_b        <= '0;
         pend_valid   <= 1'b0;
         pend_op      <= '0;
         pend_a       <= '0;
         pend_b       <= '0;
         result       <= '0;
         err          <= 1'b0;
         result_valid <= 1'b0;
         div_start    <= 1'b0;
         overflow     <= 1'b0;
         div_M        <= '0;
         div_Q        <= '0;
`ifdef ALU_TIMEOUT_EN
         cnt          <= '0;
`endif
      end else begin
         div_start <= 1'b0;
         overflow  <= 1'b0;
         case (state)
            IDLE: begin
               if (parser_done) begin
                  act_op <= op;
                  act_a  <= opa;
                  act_b  <= opb;
                  state  <= EXEC;
               end
            end
            EXEC: begin
               if (act_op != 2'b11) begin
                  result       <= alu_out;
                  err          <= 1'b0;
                  result_valid <= 1'b1;
                  state        <= OUT;
               end else if (act_b != 4'd0) begin
                  div_M     <= act_b;
                  div_Q     <= act_a;
                  div_start <= 1'b1;
                  state     <= WAIT_DIV;
`ifdef ALU_TIMEOUT_EN
                  cnt       <= '0;
`endif
               end else begin
                  result       <= 8'hFF;
                  err          <= 1'b1;
                  result_valid <= 1'b1;
                  state        <= OUT;
               end
            end
            WAIT_DIV: begin
               if (div_done) begin
                  result       <= div_result;
                  err          <= 1'b0;
                  result_valid <= 1'b1;
                  state        <= OUT;
`ifdef ALU_TIMEOUT_EN
               end else if (cnt == CW'(TIMEOUT_CYCLES - 1)) begin
                  result       <= 8'hEE;
                  err          <= 1'b1;
                  result_valid <= 1'b1;
                  state        <= OUT;
               end else begin
                  cnt <= cnt + 1'b1;
`endif
               end
            end
            default: begin
               if (transfer) begin
                  result_valid <= 1'b0;
                  if (pend_valid) begin
                     act_op     <= pend_op;
                     act_a      <= pend_a;
                     act_b      <= pend_b;
                     pend_valid <= parser_done;
                     if (parser_done) begin
                        pend_op <= op;
                        pend_a  <= opa;
                        pend_b  <= opb;
                     end
                     state <= EXEC;
                  end else if (parser_done) begin
                     act_op <= op;
                     act_a  <= opa;
                     act_b  <= opb;
                     state  <= EXEC;
                  end else begin
                     state <= IDLE;
                  end
               end
            end
         endcase

         // Requests arriving while busy; a transfer cycle already routed parser_done above
         if (parser_done && state != IDLE && !transfer) begin
            if (!pend_valid) begin
               pend_valid <= 1'b1;
               pend_op    <= op;
               pend_a     <= opa;
               pend_b     <= opb;
            end else begin
               overflow <= 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed self-checking bench for alu_sequencer; the divider is played by the bench itself.
// Build with ALU_TIMEOUT_EN defined to exercise the div_done timeout instead of the indefinite wait.
module tb_alu_sequencer;

   logic       clk;
   logic       n_rst;
   logic       parser_done;
   logic [1:0] op;
   logic [3:0] opa;
   logic [3:0] opb;
   logic [3:0] div_M;
   logic [3:0] div_Q;
   logic       div_start;
   logic [7:0] div_result;
   logic       div_done;
   logic [7:0] result;
   logic       err;
   logic       result_valid;
   logic       result_ready;
   logic       overflow;

   int total = 0;
   int bad   = 0;

   localparam int TMO = 32;

   alu_sequencer #(.TIMEOUT_CYCLES(TMO)) dut (
      .clk          (clk),
      .n_rst        (n_rst),
      .parser_done  (parser_done),
      .op           (op),
      .opa          (opa),
      .opb          (opb),
      .div_M        (div_M),
      .div_Q        (div_Q),
      .div_start    (div_start),
      .div_result   (div_result),
      .div_done     (div_done),
      .result       (result),
      .err          (err),
      .result_valid (result_valid),
      .result_ready (result_ready),
      .overflow     (overflow)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic issue(input logic [1:0] o, input logic [3:0] a, input logic [3:0] b);
      @(negedge clk);
      op          = o;
      opa         = a;
      opb         = b;
      parser_done = 1'b1;
   endtask

   task automatic test_reset();
      n_rst = 1'b0;
      tick();
      tick();
      total++;
      if ({result, err, result_valid, div_start, overflow, div_M, div_Q} !== 20'h0) begin
         bad++;
         $display("FAIL reset_outputs: got res=%h err=%b rv=%b ds=%b ov=%b M=%h Q=%h want all 0",
                  result, err, result_valid, div_start, overflow, div_M, div_Q);
      end
      @(negedge clk);
      n_rst = 1'b1;
   endtask

   task automatic test_arith();
      logic [1:0] ops [3] = '{2'b00, 2'b01, 2'b10};
      logic [3:0] as  [3] = '{4'd9, 4'd3, 4'd15};
      logic [3:0] bs  [3] = '{4'd8, 4'd5, 4'd15};
      logic [7:0] exp [3] = '{8'h11, 8'hFE, 8'hE1};
      result_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         issue(ops[i], as[i], bs[i]);
         tick();
         total++;
         if (result_valid !== 1'b0) begin
            bad++;
            $display("FAIL arith_early[%0d]: rv=%b want 0", i, result_valid);
         end
         @(negedge clk);
         parser_done = 1'b0;
         tick();
         total++;
         if (result_valid !== 1'b1 || result !== exp[i] || err !== 1'b0) begin
            bad++;
            $display("FAIL arith_result[%0d]: rv=%b res=%h err=%b want rv=1 res=%h err=0",
                     i, result_valid, result, err, exp[i]);
         end
         tick();
         total++;
         if (result_valid !== 1'b0) begin
            bad++;
            $display("FAIL arith_transfer[%0d]: rv=%b want 0", i, result_valid);
         end
      end
   endtask

   task automatic test_div();
      result_ready = 1'b1;
      issue(2'b11, 4'd7, 4'd2);
      tick();
      total++;
      if (div_start !== 1'b0) begin
         bad++;
         $display("FAIL div_start_early: ds=%b want 0", div_start);
      end
      @(negedge clk);
      parser_done = 1'b0;
      tick();
      total++;
      if (div_start !== 1'b1 || div_M !== 4'd2 || div_Q !== 4'd7) begin
         bad++;
         $display("FAIL div_launch: ds=%b M=%h Q=%h want ds=1 M=2 Q=7", div_start, div_M, div_Q);
      end
      tick();
      total++;
      if (div_start !== 1'b0 || div_M !== 4'd2 || div_Q !== 4'd7 || result_valid !== 1'b0) begin
         bad++;
         $display("FAIL div_wait: ds=%b M=%h Q=%h rv=%b want ds=0 M=2 Q=7 rv=0",
                  div_start, div_M, div_Q, result_valid);
      end
      @(negedge clk);
      div_result = 8'h5A;
      div_done   = 1'b1;
      tick();
      total++;
      if (result_valid !== 1'b1 || result !== 8'h5A || err !== 1'b0) begin
         bad++;
         $display("FAIL div_result: rv=%b res=%h err=%b want rv=1 res=5a err=0", result_valid, result, err);
      end
      @(negedge clk);
      div_done = 1'b0;
      tick();
      // stray completion while idle must be ignored
      @(negedge clk);
      div_result = 8'h99;
      div_done   = 1'b1;
      tick();
      @(negedge clk);
      div_done = 1'b0;
      tick();
      total++;
      if (result_valid !== 1'b0 || result !== 8'h5A) begin
         bad++;
         $display("FAIL div_done_idle: rv=%b res=%h want rv=0 res=5a", result_valid, result);
      end
   endtask

   task automatic test_div_zero();
      logic started = 1'b0;
      result_ready = 1'b1;
      issue(2'b11, 4'd5, 4'd0);
      tick();
      started |= div_start;
      @(negedge clk);
      parser_done = 1'b0;
      tick();
      started |= div_start;
      total++;
      if (result_valid !== 1'b1 || result !== 8'hFF || err !== 1'b1) begin
         bad++;
         $display("FAIL divzero_result: rv=%b res=%h err=%b want rv=1 res=ff err=1", result_valid, result, err);
      end
      tick();
      started |= div_start;
      tick();
      started |= div_start;
      total++;
      if (started !== 1'b0) begin
         bad++;
         $display("FAIL divzero_start: div_start seen=%b want 0", started);
      end
   endtask

   task automatic test_backpressure();
      result_ready = 1'b0;
      issue(2'b00, 4'd1, 4'd2);
      tick();
      issue(2'b01, 4'd7, 4'd1);
      tick();
      total++;
      if (overflow !== 1'b0 || result_valid !== 1'b1 || result !== 8'h03) begin
         bad++;
         $display("FAIL bp_first: ov=%b rv=%b res=%h want ov=0 rv=1 res=03", overflow, result_valid, result);
      end
      issue(2'b10, 4'd3, 4'd3);
      tick();
      total++;
      if (overflow !== 1'b1) begin
         bad++;
         $display("FAIL bp_overflow: ov=%b want 1", overflow);
      end
      @(negedge clk);
      parser_done = 1'b0;
      tick();
      total++;
      if (overflow !== 1'b0 || result_valid !== 1'b1 || result !== 8'h03) begin
         bad++;
         $display("FAIL bp_hold: ov=%b rv=%b res=%h want ov=0 rv=1 res=03", overflow, result_valid, result);
      end
      tick();
      @(negedge clk);
      result_ready = 1'b1;
      tick();
      total++;
      if (result_valid !== 1'b0) begin
         bad++;
         $display("FAIL bp_xfer1: rv=%b want 0", result_valid);
      end
      tick();
      total++;
      if (result_valid !== 1'b1 || result !== 8'h06 || err !== 1'b0) begin
         bad++;
         $display("FAIL bp_second: rv=%b res=%h err=%b want rv=1 res=06 err=0", result_valid, result, err);
      end
      tick();
      tick();
      tick();
      total++;
      if (result_valid !== 1'b0 || result !== 8'h06) begin
         bad++;
         $display("FAIL bp_dropped: rv=%b res=%h want rv=0 res=06", result_valid, result);
      end
   endtask

   task automatic test_back_to_back();
      logic ov_seen = 1'b0;
      result_ready = 1'b0;
      issue(2'b00, 4'd2, 4'd2);
      tick();
      issue(2'b00, 4'd5, 4'd5);
      tick();
      ov_seen |= overflow;
      total++;
      if (result_valid !== 1'b1 || result !== 8'h04) begin
         bad++;
         $display("FAIL b2b_first: rv=%b res=%h want rv=1 res=04", result_valid, result);
      end
      issue(2'b10, 4'd4, 4'd4);
      result_ready = 1'b1;
      tick();
      ov_seen |= overflow;
      total++;
      if (result_valid !== 1'b0) begin
         bad++;
         $display("FAIL b2b_xfer: rv=%b want 0", result_valid);
      end
      @(negedge clk);
      parser_done  = 1'b0;
      result_ready = 1'b0;
      tick();
      ov_seen |= overflow;
      total++;
      if (result_valid !== 1'b1 || result !== 8'h0A) begin
         bad++;
         $display("FAIL b2b_second: rv=%b res=%h want rv=1 res=0a", result_valid, result);
      end
      @(negedge clk);
      result_ready = 1'b1;
      tick();
      tick();
      ov_seen |= overflow;
      total++;
      if (result_valid !== 1'b1 || result !== 8'h10) begin
         bad++;
         $display("FAIL b2b_third: rv=%b res=%h want rv=1 res=10", result_valid, result);
      end
      tick();
      total++;
      if (result_valid !== 1'b0 || ov_seen !== 1'b0) begin
         bad++;
         $display("FAIL b2b_end: rv=%b overflow_seen=%b want 0 0", result_valid, ov_seen);
      end
   endtask

   task automatic test_reset_mid_div();
      result_ready = 1'b1;
      issue(2'b11, 4'd9, 4'd4);
      tick();
      @(negedge clk);
      parser_done = 1'b0;
      tick();
      tick();
      @(negedge clk);
      n_rst = 1'b0;
      tick();
      total++;
      if ({result, err, result_valid, div_start, overflow, div_M, div_Q} !== 20'h0) begin
         bad++;
         $display("FAIL rst_mid: got res=%h err=%b rv=%b ds=%b ov=%b M=%h Q=%h want all 0",
                  result, err, result_valid, div_start, overflow, div_M, div_Q);
      end
      @(negedge clk);
      n_rst      = 1'b1;
      div_result = 8'h77;
      div_done   = 1'b1;
      tick();
      @(negedge clk);
      div_done = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         total++;
         if (result_valid !== 1'b0 || result !== 8'h00) begin
            bad++;
            $display("FAIL rst_late_done[%0d]: rv=%b res=%h want rv=0 res=00", i, result_valid, result);
         end
      end
   endtask

   task automatic test_div_wait();
      result_ready = 1'b0;
      issue(2'b11, 4'd8, 4'd2);
      tick();
      @(negedge clk);
      parser_done = 1'b0;
      tick();
`ifdef ALU_TIMEOUT_EN
      for (int i = 1; i < TMO; i++) tick();
      total++;
      if (result_valid !== 1'b0) begin
         bad++;
         $display("FAIL tmo_early: rv=%b want 0", result_valid);
      end
      tick();
      total++;
      if (result_valid !== 1'b1 || result !== 8'hEE || err !== 1'b1) begin
         bad++;
         $display("FAIL tmo_result: rv=%b res=%h err=%b want rv=1 res=ee err=1", result_valid, result, err);
      end
      @(negedge clk);
      div_result = 8'h44;
      div_done   = 1'b1;
      tick();
      @(negedge clk);
      div_done = 1'b0;
      total++;
      if (result !== 8'hEE || err !== 1'b1 || result_valid !== 1'b1) begin
         bad++;
         $display("FAIL tmo_late_done: rv=%b res=%h err=%b want rv=1 res=ee err=1", result_valid, result, err);
      end
`else
      for (int i = 0; i < 40; i++) begin
         tick();
         total++;
         if (result_valid !== 1'b0) begin
            bad++;
            $display("FAIL wait_forever[%0d]: rv=%b want 0", i, result_valid);
         end
      end
      @(negedge clk);
      div_result = 8'h04;
      div_done   = 1'b1;
      tick();
      @(negedge clk);
      div_done = 1'b0;
      total++;
      if (result_valid !== 1'b1 || result !== 8'h04 || err !== 1'b0) begin
         bad++;
         $display("FAIL wait_result: rv=%b res=%h err=%b want rv=1 res=04 err=0", result_valid, result, err);
      end
`endif
      result_ready = 1'b1;
      tick();
      tick();
      total++;
      if (result_valid !== 1'b0) begin
         bad++;
         $display("FAIL wait_drain: rv=%b want 0", result_valid);
      end
   endtask

   initial begin
      n_rst        = 1'b0;
      parser_done  = 1'b0;
      op           = '0;
      opa          = '0;
      opb          = '0;
      div_result   = '0;
      div_done     = 1'b0;
      result_ready = 1'b0;
      test_reset();
      test_arith();
      test_div();
      test_div_zero();
      test_backpressure();
      test_back_to_back();
      test_reset_mid_div();
      test_div_wait();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
